// File: rtl/data_mem_ring.sv
// Per-channel circular sample history for the MSDAP datapath.
// After reset a flush FSM clears every entry, one per cycle, before samples are accepted.
// Writes append at a per-channel head pointer. Reads fetch x[n-k] by offset k with one cycle of latency.
// Handshake: a read is requested by readEnable and answered one cycle later.
// The answer is dataValueOut qualified by a one-cycle dataValid pulse.
// No back-pressure exists, and a request can be issued every cycle.
module data_mem_ring #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8,
   parameter int NUM_CH = 2,
   parameter int CH_W   = 1
) (
   input  logic              sClk,
   input  logic              memReset_n,
   input  logic              writeEnable,
   input  logic [CH_W-1:0]   wrCh,
   input  logic [DATA_W-1:0] dataValueIn,
   input  logic              readEnable,
   input  logic [CH_W-1:0]   rdCh,
   input  logic [ADDR_W-1:0] rdOffset,
   output logic [DATA_W-1:0] dataValueOut,
   output logic              dataValid,
   output logic              flushBusy,
   output logic              writeDropped
);

   localparam int MEM_SIZE = NUM_CH * DEPTH;
   localparam int IDX_W    = CH_W + ADDR_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_SIZE - 1);

   localparam logic [0:0] ST_FLUSH = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   logic [0:0]        state;
   logic [IDX_W-1:0]  flush_idx;
   logic [DATA_W-1:0] mem [MEM_SIZE];
   logic [ADDR_W-1:0] head [NUM_CH];

   logic              is_ready;
   logic              wr_ch_ok;
   logic              rd_ch_ok;
   logic              do_write;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;

   assign is_ready  = (state == ST_READY);
   assign flushBusy = (state == ST_FLUSH);
   assign wr_ch_ok  = (32'(wrCh) < NUM_CH);
   assign rd_ch_ok  = (32'(rdCh) < NUM_CH);
   assign do_write  = is_ready && writeEnable && wr_ch_ok;

   // Address decode: the newest sample sits one slot behind the head, and offset k steps further back.
   always_comb begin
      wr_ptr = '0;
      rd_ptr = '0;
      if (wr_ch_ok) wr_ptr = head[wrCh];
      if (rd_ch_ok) rd_ptr = head[rdCh] - ADDR_W'(1) - rdOffset;
      wr_idx = {wrCh, wr_ptr};
      rd_idx = {rdCh, rd_ptr};
   end

   // Flush FSM: walk every entry once, channel-major, then hand over to normal operation.
   always_ff @(posedge sClk) begin
      if (!memReset_n) begin
         state     <= ST_FLUSH;
         flush_idx <= '0;
      end else if (state == ST_FLUSH) begin
         if (flush_idx == LAST_IDX) begin
            state     <= ST_READY;
            flush_idx <= '0;
         end else begin
            flush_idx <= flush_idx + IDX_W'(1);
         end
      end
   end

   // Head pointers: each channel advances only on its own accepted write and wraps silently.
   always_ff @(posedge sClk) begin
      if (!memReset_n) begin
         for (int c = 0; c < NUM_CH; c++) head[c] <= '0;
      end else if (do_write) begin
         head[wrCh] <= head[wrCh] + ADDR_W'(1);
      end
   end

   // Storage: flush clears take priority, and reset itself leaves contents alone.
   always_ff @(posedge sClk) begin
      if (memReset_n) begin
         if (state == ST_FLUSH) mem[flush_idx] <= '0;
         else if (do_write)     mem[wr_idx]    <= dataValueIn;
      end
   end

   // Registered read port: it samples storage before this edge's write, which gives read-before-write.
   always_ff @(posedge sClk) begin
      if (!memReset_n) begin
         dataValueOut <= '0;
         dataValid    <= 1'b0;
         writeDropped <= 1'b0;
      end else begin
         dataValid    <= readEnable;
         writeDropped <= writeEnable && !(is_ready && wr_ch_ok);
         if (readEnable) dataValueOut <= (is_ready && rd_ch_ok) ? mem[rd_idx] : '0;
      end
   end

endmodule

// File: tb/tb_data_mem_ring.sv
// Bench for data_mem_ring: randomized and directed traffic checked against a sample-history model.
module tb_data_mem_ring;

   localparam int DW    = 16;
   localparam int DEPTH = 256;
   localparam int AW    = 8;
   localparam int NCH   = 2;
   localparam int CW    = 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n = 1'b1;
   logic          we    = 1'b0;
   logic [CW-1:0] wr_ch = '0;
   logic [DW-1:0] din   = '0;
   logic          re    = 1'b0;
   logic [CW-1:0] rd_ch = '0;
   logic [AW-1:0] rd_off = '0;
   logic [DW-1:0] dout;
   logic          dv;
   logic          busy;
   logic          wdrop;

   data_mem_ring #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .NUM_CH(NCH), .CH_W(CW)) dut (
      .sClk(clk), .memReset_n(rst_n), .writeEnable(we), .wrCh(wr_ch), .dataValueIn(din),
      .readEnable(re), .rdCh(rd_ch), .rdOffset(rd_off), .dataValueOut(dout),
      .dataValid(dv), .flushBusy(busy), .writeDropped(wdrop)
   );

   // ---------------- scoreboard ----------------
   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // hist[ch][k] is x[n-k] for that channel; a write pushes a new x[n] and discards the oldest.
   logic [DW-1:0] hist [NCH][DEPTH];
   int            flush_left = 0;
   bit            started = 0;
   logic [DW-1:0] m_out;
   logic          m_valid, m_drop, m_busy;

   always @(posedge clk) begin : model
      bit busy_before;
      if (!rst_n) begin
         started    = 1;
         flush_left = NCH * DEPTH;
         m_out      = '0;
         m_valid    = 1'b0;
         m_drop     = 1'b0;
         for (int c = 0; c < NCH; c++)
            for (int k = 0; k < DEPTH; k++) hist[c][k] = '0;
      end else if (started) begin
         busy_before = (flush_left > 0);
         m_valid = re;
         m_drop  = we && (busy_before || int'(wr_ch) >= NCH);
         if (re) m_out = (busy_before || int'(rd_ch) >= NCH) ? '0 : hist[int'(rd_ch)][int'(rd_off)];
         if (we && !busy_before && int'(wr_ch) < NCH) begin
            for (int i = DEPTH - 1; i > 0; i--) hist[int'(wr_ch)][i] = hist[int'(wr_ch)][i-1];
            hist[int'(wr_ch)][0] = din;
         end
         if (flush_left > 0) flush_left--;
      end
      m_busy = (flush_left > 0);
   end

   // Compare every output on every cycle once the first reset has been applied.
   always @(negedge clk) begin
      if (started) begin
         check("dataValueOut", 32'(dout), 32'(m_out));
         check("dataValid", 32'(dv), 32'(m_valid));
         check("writeDropped", 32'(wdrop), 32'(m_drop));
         check("flushBusy", 32'(busy), 32'(m_busy));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int ch, input int v);
      we = 1'b1; wr_ch = CW'(ch); din = DW'(v);
      cyc();
      we = 1'b0;
   endtask

   task automatic rd(input int ch, input int k);
      re = 1'b1; rd_ch = CW'(ch); rd_off = AW'(k);
      cyc();
      re = 1'b0;
   endtask

   task automatic rd_lit(input string name, input int ch, input int k, input logic [DW-1:0] e);
      rd(ch, k);
      check(name, 32'(dout), 32'(e));
      check({name, "_valid"}, 32'(dv), 32'd1);
   endtask

   task automatic reset_and_flush(input string name);
      int n;
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
      n = 0;
      while (busy && n < 2000) begin
         cyc();
         n++;
      end
      check(name, 32'(n), 32'd512);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // 1: flush length, then every entry reads back zero
      reset_and_flush("flush_len_initial");
      for (int c = 0; c < NCH; c++)
         for (int k = 0; k < DEPTH; k++) rd(c, k);
      rd_lit("zero_ch1_k255", 1, 255, 16'h0000);

      // 2: three appends to ch0, read back newest first
      wr(0, 16'h1111); wr(0, 16'h2222); wr(0, 16'h3333);
      rd_lit("ch0_k0", 0, 0, 16'h3333);
      rd_lit("ch0_k1", 0, 1, 16'h2222);
      rd_lit("ch0_k2", 0, 2, 16'h1111);

      // 3: 257 appends to ch1 wrap once; ch0 untouched
      for (int i = 0; i <= 256; i++) wr(1, i);
      rd_lit("ch1_k0_wrap", 1, 0, 16'h0100);
      rd_lit("ch1_k255_wrap", 1, 255, 16'h0001);
      rd_lit("ch0_untouched", 0, 0, 16'h3333);

      // 4: fill ch0, then same-cycle write and read of the slot being overwritten
      for (int i = 0; i < 256; i++) wr(0, i);
      we = 1'b1; wr_ch = 1'b0; din = 16'hBEEF;
      re = 1'b1; rd_ch = 1'b0; rd_off = 8'd255;
      cyc();
      we = 1'b0; re = 1'b0;
      check("rbw_old_value", 32'(dout), 32'h0000);
      rd_lit("rbw_new_k0", 0, 0, 16'hBEEF);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         we     = 1'($urandom_range(0, 1));
         wr_ch  = CW'($urandom_range(0, NCH - 1));
         din    = DW'($urandom);
         re     = 1'($urandom_range(0, 1));
         rd_ch  = CW'($urandom_range(0, NCH - 1));
         rd_off = ($urandom_range(0, 7) == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, DEPTH - 1));
         cyc();
      end
      we = 1'b0; re = 1'b0;

      // 5: write during flush is dropped; reset at flush cycle 100 restarts the flush
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      repeat (50) cyc();
      wr(0, 16'hDEAD);
      check("drop_in_flush", 32'(wdrop), 32'd1);
      rd(0, 0);
      check("read_in_flush_zero", 32'(dout), 32'h0000);
      repeat (48) cyc();
      reset_and_flush("flush_len_restart");
      wr(0, 16'hA5A5);
      rd_lit("head_unchanged_k0", 0, 0, 16'hA5A5);
      rd_lit("head_unchanged_k1", 0, 1, 16'h0000);

      // 6: reset in READY clears outputs, and re-flush zeroes both channels
      wr(1, 16'h7777);
      rd(1, 0);
      rst_n = 1'b0;
      cyc();
      check("reset_dout", 32'(dout), 32'h0000);
      check("reset_valid", 32'(dv), 32'd0);
      reset_and_flush("flush_len_ready_reset");
      rd_lit("reflush_ch0_k0", 0, 0, 16'h0000);
      rd_lit("reflush_ch1_k0", 1, 0, 16'h0000);

      repeat (3) cyc();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
